// File: rtl/fixed_pkg.sv
// Shared fixed-point definitions for the GRU datapath (multiplier and adder).
package fixed_pkg;
  localparam int W    = 16;
  localparam int FRAC = 8;
  localparam int MAGW = W - 1;
  localparam int ACCW = 2 * MAGW;

  localparam logic [MAGW-1:0] SAT_MAX = 15'h7FFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    NORM = 2'd2
  } state_t;

  typedef struct packed {
    logic            sign;
    logic [MAGW-1:0] mag;
  } sm_word_t;
endpackage

// File: rtl/fixed_round_sat.sv
// Rounds a full-width product magnitude half-up, saturates to W-1 bits and
// canonicalises negative zero.
module fixed_round_sat
  import fixed_pkg::*;
(
  input  logic [ACCW-1:0] mag,
  input  logic            sign,
  output logic [W-1:0]    prod,
  output logic            ovf
);
  localparam logic [ACCW:0] HALF = (ACCW+1)'(1) << (FRAC - 1);

  logic [ACCW:0]   sum;
  logic [ACCW:0]   r;
  logic [MAGW-1:0] mag_out;
  sm_word_t        word;

  always_comb begin
    sum = {1'b0, mag} + HALF;
    r   = sum >> FRAC;
    if (r > (ACCW+1)'(SAT_MAX)) begin
      mag_out = SAT_MAX;
      ovf     = 1'b1;
    end else begin
      mag_out = r[MAGW-1:0];
      ovf     = 1'b0;
    end
    word.mag  = mag_out;
    word.sign = (mag_out == '0) ? 1'b0 : sign;
    prod      = word;
  end
endmodule

// File: rtl/fixed_mul_seq.sv
// Sequential sign-magnitude fixed-point multiplier: one multiplier bit per
// cycle, then a single round/saturate cycle before the result is presented.
module fixed_mul_seq
  import fixed_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         cs_mul,
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  output logic [W-1:0] prod,
  output logic         rdy_mul,
  output logic         ovf_mul
);
  // Handshake: cs_mul is taken only on an edge where the block is idle
  // (rdy_mul=1); prod/ovf_mul are valid whenever rdy_mul is high and hold
  // until the next result or reset. Requests while busy are dropped.

  state_t          state;
  logic [MAGW-1:0] mx;
  logic [MAGW-1:0] my;
  logic            s;
  logic [ACCW-1:0] acc;
  logic [3:0]      cnt;

  logic [W-1:0]    rs_prod;
  logic            rs_ovf;

  fixed_round_sat u_round_sat (
    .mag  (acc),
    .sign (s),
    .prod (rs_prod),
    .ovf  (rs_ovf)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      rdy_mul <= 1'b1;
      prod    <= '0;
      ovf_mul <= 1'b0;
      acc     <= '0;
      cnt     <= '0;
      mx      <= '0;
      my      <= '0;
      s       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cs_mul) begin
            mx      <= x[MAGW-1:0];
            my      <= y[MAGW-1:0];
            s       <= x[W-1] ^ y[W-1];
            acc     <= '0;
            cnt     <= '0;
            rdy_mul <= 1'b0;
            state   <= MULT;
          end
        end
        MULT: begin
          if (my[cnt])
            acc <= acc + ({{MAGW{1'b0}}, mx} << cnt);
          if (cnt == 4'(MAGW - 1))
            state <= NORM;
          else
            cnt <= cnt + 4'd1;
        end
        NORM: begin
          prod    <= rs_prod;
          ovf_mul <= rs_ovf;
          rdy_mul <= 1'b1;
          state   <= IDLE;
        end
        default: begin
          rdy_mul <= 1'b1;
          state   <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_fixed_mul_seq.sv
// Directed self-checking bench for fixed_mul_seq.
module tb_fixed_mul_seq;
  logic        clk;
  logic        rst;
  logic        cs_mul;
  logic [15:0] x;
  logic [15:0] y;
  logic [15:0] prod;
  logic        rdy_mul;
  logic        ovf_mul;

  int n_tests = 0;
  int n_fail  = 0;

  logic [16:0] exp_q[$];

  fixed_mul_seq dut (
    .clk     (clk),
    .rst     (rst),
    .cs_mul  (cs_mul),
    .x       (x),
    .y       (y),
    .prod    (prod),
    .rdy_mul (rdy_mul),
    .ovf_mul (ovf_mul)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for rdy_mul; returns edges elapsed since the capture edge (0 on timeout).
  task automatic wait_rdy(output int lat);
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      if (lat == 0) begin
        tick();
        if (rdy_mul) lat = i;
      end
    end
  endtask

  task automatic scoreboard(input string tag);
    logic [16:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_queue"}, 32'(exp_q.size()), 32'd1);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_prod"}, 32'(prod), 32'(e[15:0]));
      check({tag, "_ovf"}, 32'(ovf_mul), 32'(e[16]));
    end
  endtask

  task automatic run_op(input string tag, input logic [15:0] xa, input logic [15:0] ya,
                        input logic [15:0] ep, input logic eo);
    int lat;
    exp_q.push_back({eo, ep});
    cs_mul = 1'b1;
    x = xa;
    y = ya;
    tick();
    cs_mul = 1'b0;
    x = $urandom_range(0, 16'hFFFF);
    y = $urandom_range(0, 16'hFFFF);
    check({tag, "_busy"}, 32'(rdy_mul), 32'd0);
    wait_rdy(lat);
    check({tag, "_lat"}, 32'(lat), 32'd16);
    scoreboard(tag);
  endtask

  initial begin
    int lat;
    rst = 1'b1;
    cs_mul = 1'b0;
    x = '0;
    y = '0;
    tick();
    tick();
    check("reset_rdy", 32'(rdy_mul), 32'd1);
    check("reset_prod", 32'(prod), 32'd0);
    check("reset_ovf", 32'(ovf_mul), 32'd0);
    rst = 1'b0;
    tick();

    run_op("basic",   16'h0180, 16'h0200, 16'h0300, 1'b0);
    run_op("neg_pos", 16'h8180, 16'h0200, 16'h8300, 1'b0);
    run_op("neg_neg", 16'h8180, 16'h8200, 16'h0300, 1'b0);
    run_op("half_up", 16'h0001, 16'h0080, 16'h0001, 1'b0);
    run_op("round_0", 16'h0001, 16'h007F, 16'h0000, 1'b0);
    run_op("neg_0",   16'h8000, 16'h0100, 16'h0000, 1'b0);
    run_op("sat",     16'h7FFF, 16'h7FFF, 16'h7FFF, 1'b1);
    check("sat_hold_prod", 32'(prod), 32'h7FFF);
    tick();
    check("sat_hold_ovf", 32'(ovf_mul), 32'd1);
    run_op("after_sat", 16'h0100, 16'h0100, 16'h0100, 1'b0);

    // cs_mul pulsed while busy must be ignored
    exp_q.push_back({1'b0, 16'h8300});
    cs_mul = 1'b1;
    x = 16'h8180;
    y = 16'h0200;
    tick();
    cs_mul = 1'b0;
    lat = 0;
    for (int e = 1; e <= 40; e++) begin
      if (lat == 0) begin
        cs_mul = (e >= 3 && e <= 10);
        x = 16'h7FFF;
        y = 16'h7FFF;
        tick();
        if (rdy_mul) lat = e;
      end
    end
    cs_mul = 1'b0;
    check("busy_cs_lat", 32'(lat), 32'd16);
    scoreboard("busy_cs");
    tick();
    check("busy_cs_idle", 32'(rdy_mul), 32'd1);

    // cs_mul held high: second capture at edge 17; input changes after edge 0 ignored
    exp_q.push_back({1'b0, 16'h0300});
    exp_q.push_back({1'b0, 16'h0100});
    cs_mul = 1'b1;
    x = 16'h0180;
    y = 16'h0200;
    tick();
    x = 16'h0100;
    y = 16'h0100;
    wait_rdy(lat);
    check("b2b_lat0", 32'(lat), 32'd16);
    scoreboard("b2b_first");
    tick();
    cs_mul = 1'b0;
    check("b2b_capture17", 32'(rdy_mul), 32'd0);
    wait_rdy(lat);
    check("b2b_lat1", 32'(lat), 32'd16);
    scoreboard("b2b_second");

    // reset asserted on edge 8 of an operation
    cs_mul = 1'b1;
    x = 16'h0180;
    y = 16'h0200;
    tick();
    cs_mul = 1'b0;
    for (int e = 1; e <= 7; e++) tick();
    check("pre_rst_busy", 32'(rdy_mul), 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_rdy", 32'(rdy_mul), 32'd1);
    check("midrst_prod", 32'(prod), 32'd0);
    check("midrst_ovf", 32'(ovf_mul), 32'd0);
    check("midrst_state", 32'(dut.state), 32'd0);
    run_op("post_rst", 16'h8180, 16'h8200, 16'h0300, 1'b0);

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
